seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the calculator's N-digit common-anode 7-seg display.

---
 rtl/seven_seg_scan_ctrl.sv | 74 +++++++
 tb/tb_seven_seg_scan_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed N-digit common-anode 7-seg scanner with tear-free frame and dead time (optional LEADING_ZERO_BLANK_EN)
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic                    pending,
  output logic [3:0]              dec_x,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] shadow, active;
  logic slot_end, wrap, blank;
  logic [3:0] nib;
  assign slot_end = en && cnt == CW'(REFRESH_DIV - 1);
  assign wrap = slot_end && idx == LAST;
  assign nib = active[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  // locate the most significant nonzero digit; digit 0 is always shown
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (active[4*i +: 4] != 4'd0) msd = IW'(i);
  end
  assign blank = nib > 4'd9 || idx > msd;
`else
  assign blank = nib > 4'd9;
`endif
  // prescaler and digit index, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == LAST ? '0 : idx + 1'b1;
    end
  end
  // shadow capture and frame-boundary transfer; a load on the wrap cycle goes straight to active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= bcd_in;
      if (wrap) active <= load ? bcd_in : shadow;
      pending <= load ? !wrap : (wrap ? 1'b0 : pending);
    end
  end
  // registered pin outputs; dec_x changes in the dead time before the anode turns on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_x      <= 4'd0;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      dec_x      <= nib;
      an         <= (en && cnt >= CW'(DEAD_CYCLES) && !blank) ? ~(NUM_DIGITS'(1) << idx) : '1;
      frame_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed checks of scan timing, frame loading, blanking and enable hold
module tb_seven_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [15:0] bcd_in = '0;
  logic load = 1'b0;
  logic pending, frame_tick;
  logic [3:0] dec_x, an;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bcd_in(bcd_in), .load(load),
    .pending(pending), .dec_x(dec_x), .an(an), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic adv(input int k);
    while (cyc < k) step();
  endtask
  task automatic pulse_load(input logic [15:0] v);
    load = 1'b1;
    bcd_in = v;
    step();
    load = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_dec", dec_x, 0);
    check("rst_pend", pending, 0);
    check("rst_tick", frame_tick, 0);
    rst_n = 1'b1;
    adv(2);
    check("dead_an2", an, 4'hF);
    adv(3);
    check("d0_an", an, 4'hE);
    check("d0_dec", dec_x, 0);
    adv(4);
    pulse_load(16'h1234);
    check("ld_pend", pending, 1);
    adv(11);
    check("d1_an", an, 4'hD);
    adv(19);
    check("d2_an", an, 4'hB);
    adv(27);
    check("d3_an", an, 4'h7);
    check("old_dec", dec_x, 0);
    adv(31);
    check("pend_hold", pending, 1);
    check("tick_pre", frame_tick, 0);
    adv(32);
    check("tick32", frame_tick, 1);
    check("pend_clr", pending, 0);
    adv(33);
    check("tick_1cyc", frame_tick, 0);
    adv(35);
    check("f2_d0_an", an, 4'hE);
    check("f2_d0_dec", dec_x, 4);
    adv(43);
    check("f2_d1", {an, dec_x}, {4'hD, 4'd3});
    adv(51);
    check("f2_d2", {an, dec_x}, {4'hB, 4'd2});
    adv(59);
    check("f2_d3", {an, dec_x}, {4'h7, 4'd1});
    adv(64);
    check("tick64", frame_tick, 1);
    adv(95);
    pulse_load(16'h5678);
    check("wrapld_pend", pending, 0);
    check("tick96", frame_tick, 1);
    adv(97);
    check("wrapld_pend2", pending, 0);
    adv(99);
    check("f3_d0", {an, dec_x}, {4'hE, 4'd8});
    pulse_load(16'h12A4);
    check("inv_pend", pending, 1);
    adv(107);
    check("f3_d1", {an, dec_x}, {4'hD, 4'd7});
    adv(115);
    check("f3_d2", {an, dec_x}, {4'hB, 4'd6});
    adv(123);
    check("f3_d3", {an, dec_x}, {4'h7, 4'd5});
    adv(131);
    check("inv_d0", {an, dec_x}, {4'hE, 4'd4});
    for (int k = 137; k <= 144; k++) begin
      adv(k);
      check("inv_blank", an, 4'hF);
      if (k == 140) check("inv_dec", dec_x, 4'hA);
    end
    adv(147);
    check("inv_d2", {an, dec_x}, {4'hB, 4'd2});
    adv(155);
    check("inv_d3", {an, dec_x}, {4'h7, 4'd1});
    adv(164);
    check("pre_dis", an, 4'hE);
    en = 1'b0;
    adv(165);
    check("dis_an", an, 4'hF);
    check("dis_tick", frame_tick, 0);
    adv(170);
    pulse_load(16'h9876);
    check("dis_pend", pending, 1);
    adv(175);
    check("dis_an2", an, 4'hF);
    adv(184);
    check("dis_an3", an, 4'hF);
    check("dis_pend2", pending, 1);
    check("dis_tick2", frame_tick, 0);
    en = 1'b1;
    adv(185);
    check("resume", {an, dec_x}, {4'hE, 4'd4});
    adv(211);
    check("res_pend", pending, 1);
    check("res_tick0", frame_tick, 0);
    adv(212);
    check("res_tick", frame_tick, 1);
    check("res_pclr", pending, 0);
    adv(215);
    check("res_new", {an, dec_x}, {4'hE, 4'd6});
    adv(216);
    pulse_load(16'h0070);
    adv(244);
    check("lz_tick", frame_tick, 1);
    adv(247);
    check("lz_d0", {an, dec_x}, {4'hE, 4'd0});
    adv(249);
    pulse_load(16'h0000);
    adv(255);
    check("lz_d1", {an, dec_x}, {4'hD, 4'd7});
`ifdef LEADING_ZERO_BLANK_EN
    adv(263);
    check("lz_d2", an, 4'hF);
    adv(271);
    check("lz_d3", an, 4'hF);
    adv(279);
    check("z_d0", {an, dec_x}, {4'hE, 4'd0});
    adv(287);
    check("z_d1", an, 4'hF);
`else
    adv(263);
    check("lz_d2", {an, dec_x}, {4'hB, 4'd0});
    adv(271);
    check("lz_d3", {an, dec_x}, {4'h7, 4'd0});
    adv(279);
    check("z_d0", {an, dec_x}, {4'hE, 4'd0});
    adv(287);
    check("z_d1", {an, dec_x}, {4'hD, 4'd0});
`endif
    adv(290);
    pulse_load(16'h4321);
    check("pre_rst_pend", pending, 1);
    rst_n = 1'b0;
    #1;
    check("async_an", an, 4'hF);
    check("async_pend", pending, 0);
    check("async_dec", dec_x, 0);
    check("async_tick", frame_tick, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
